// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring radix-2 integer divider feeding CDB input 2.
module div_unit #(
    parameter int WIDTH   = 32,
    parameter int LABEL_W = 4
) (
    input  logic               clk,
    input  logic               nRST,
    input  logic               WEN,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   dataIn1,
    input  logic [WIDTH-1:0]   dataIn2,
    input  logic [LABEL_W-1:0] labelIn,
    output logic               available,
    output logic               require,
    input  logic               requireAC,
    output logic [WIDTH-1:0]   result,
    output logic [LABEL_W-1:0] labelOut
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state, state_n;
    logic               is_rem, neg_q, neg_r, sgn, neg_a, neg_b, accept, last, ge;
    logic [LABEL_W-1:0] label_r;
    logic [WIDTH-1:0]   q, dvsr, dvnd, res, rem, a_abs, b_abs, q_nxt, rem_nxt, q_fix, r_fix, fin;
    logic [WIDTH:0]     rem_sh;
    logic [CW-1:0]      cnt;

    assign sgn    = ~op[0];
    assign neg_a  = sgn & dataIn1[WIDTH-1];
    assign neg_b  = sgn & dataIn2[WIDTH-1];
    assign a_abs  = neg_a ? -dataIn1 : dataIn1;
    assign b_abs  = neg_b ? -dataIn2 : dataIn2;
    assign accept = state == IDLE && WEN && labelIn != '0;
    assign last   = state == BUSY && cnt == LAST;

    // q shifts the dividend out at the top while quotient bits enter at the bottom
    assign rem_sh  = {rem, q[WIDTH-1]};
    assign ge      = rem_sh >= {1'b0, dvsr};
    assign rem_nxt = ge ? WIDTH'(rem_sh - {1'b0, dvsr}) : rem_sh[WIDTH-1:0];
    assign q_nxt   = {q[WIDTH-2:0], ge};
    assign q_fix   = neg_q ? -q_nxt : q_nxt;
    assign r_fix   = neg_r ? -rem_nxt : rem_nxt;
    // a zero divisor bypasses the sign fix-up: all-ones quotient, untouched dividend
    assign fin     = dvsr == '0 ? (is_rem ? dvnd : '1) : (is_rem ? r_fix : q_fix);

    assign available = state == IDLE;
    assign require   = state == DONE;
    assign result    = require ? res : '0;
    assign labelOut  = require ? label_r : '0;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (accept) state_n = BUSY;
        if (last) state_n = DONE;
        if (state == DONE && requireAC) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            is_rem  <= 1'b0;
            label_r <= '0;
            q       <= '0;
            dvsr    <= '0;
            dvnd    <= '0;
            rem     <= '0;
            res     <= '0;
            cnt     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (accept) begin
            is_rem  <= op[1];
            label_r <= labelIn;
            q       <= a_abs;
            dvsr    <= b_abs;
            dvnd    <= dataIn1;
            rem     <= '0;
            cnt     <= '0;
            neg_q   <= neg_a ^ neg_b;
            neg_r   <= neg_a;
        end else if (state == BUSY) begin
            q   <= q_nxt;
            rem <= rem_nxt;
            cnt <= cnt + 1'b1;
            if (last) res <= fin;
        end else if (state == DONE && requireAC) begin
            res     <= '0;
            label_r <= '0;
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: table-driven vectors plus scoreboard for div_unit corner cases.
module tb_div_unit;
    localparam int W  = 32;
    localparam int LW = 4;

    logic          clk = 1'b0, nRST = 1'b0, WEN = 1'b0, requireAC = 1'b0;
    logic [1:0]    op = '0;
    logic [W-1:0]  dataIn1 = '0, dataIn2 = '0;
    logic [LW-1:0] labelIn = '0;
    logic          available, require;
    logic [W-1:0]  result;
    logic [LW-1:0] labelOut;

    typedef struct {
        logic [1:0]    op;
        logic [W-1:0]  a, b;
        logic [LW-1:0] lab;
        logic [W-1:0]  exp;
    } vec_t;
    typedef struct {
        logic [W-1:0]  res;
        logic [LW-1:0] lab;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[14];
    int   errors = 0, checks = 0;

    div_unit #(.WIDTH(W), .LABEL_W(LW)) dut (
        .clk(clk), .nRST(nRST), .WEN(WEN), .op(op), .dataIn1(dataIn1), .dataIn2(dataIn2),
        .labelIn(labelIn), .available(available), .require(require), .requireAC(requireAC),
        .result(result), .labelOut(labelOut)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [LW-1:0] lab, input logic [W-1:0] exp);
        exp_t e;
        @(negedge clk);
        op = o; dataIn1 = a; dataIn2 = b; labelIn = lab; WEN = 1'b1;
        e.res = exp; e.lab = lab;
        sb.push_back(e);
        @(negedge clk);
        WEN = 1'b0; labelIn = '0;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!require && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_out(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: result %h appeared with empty scoreboard", name, result);
        end else begin
            e = sb.pop_front();
            chk({name, " result"}, result, e.res);
            chk({name, " label"}, W'(labelOut), W'(e.lab));
        end
    endtask

    task automatic grant(input string name);
        requireAC = 1'b1;
        @(negedge clk);
        requireAC = 1'b0; WEN = 1'b0; labelIn = '0;
        chk({name, " avail after grant"}, W'(available), 1);
        chk({name, " req after grant"}, W'(require), 0);
        chk({name, " result after grant"}, result, 0);
        chk({name, " label after grant"}, W'(labelOut), 0);
    endtask

    task automatic quiet(input string name);
        int hits = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (require) hits++;
        end
        chk({name, " no request"}, W'(hits), 0);
    endtask

    initial begin
        int n;
        vecs[0]  = '{2'b00, 32'd100,        32'd7,          4'd5,  32'd14};
        vecs[1]  = '{2'b00, 32'hFFFFFFF9,   32'd2,          4'd1,  32'hFFFFFFFD};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9,   32'd2,          4'd2,  32'hFFFFFFFF};
        vecs[3]  = '{2'b01, 32'hFFFFFFF9,   32'd2,          4'd3,  32'h7FFFFFFC};
        vecs[4]  = '{2'b00, 32'd1234,       32'd0,          4'd4,  32'hFFFFFFFF};
        vecs[5]  = '{2'b10, 32'd1234,       32'd0,          4'd6,  32'h000004D2};
        vecs[6]  = '{2'b00, 32'h80000000,   32'hFFFFFFFF,   4'd7,  32'h80000000};
        vecs[7]  = '{2'b10, 32'h80000000,   32'hFFFFFFFF,   4'd8,  32'd0};
        vecs[8]  = '{2'b11, 32'd100,        32'd7,          4'd9,  32'd2};
        vecs[9]  = '{2'b00, 32'd7,          32'hFFFFFFFE,   4'd10, 32'hFFFFFFFD};
        vecs[10] = '{2'b10, 32'd7,          32'hFFFFFFFE,   4'd11, 32'd1};
        vecs[11] = '{2'b10, 32'hFFFFFFF9,   32'd0,          4'd12, 32'hFFFFFFF9};
        vecs[12] = '{2'b01, 32'd1234,       32'd0,          4'd13, 32'hFFFFFFFF};
        vecs[13] = '{2'b11, 32'hFFFFFFF9,   32'd0,          4'd15, 32'hFFFFFFF9};

        #1;
        chk("reset avail", W'(available), 1);
        chk("reset req", W'(require), 0);
        chk("reset result", result, 0);
        chk("reset label", W'(labelOut), 0);
        @(negedge clk);
        nRST = 1'b1;

        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lab, vecs[i].exp);
            chk($sformatf("vec%0d busy avail", i), W'(available), 0);
            wait_req(n);
            chk($sformatf("vec%0d latency", i), W'(n), 32);
            check_out($sformatf("vec%0d", i));
            grant($sformatf("vec%0d", i));
        end

        // backpressure with WEN pulses in BUSY and DONE, and WEN during the grant cycle
        issue(2'b00, 32'd50, 32'd5, 4'd6, 32'd10);
        WEN = 1'b1; labelIn = 4'd7; dataIn1 = 32'd1000; dataIn2 = 32'd1;
        chk("bp busy avail", W'(available), 0);
        @(negedge clk);
        WEN = 1'b0; labelIn = '0;
        wait_req(n);
        chk("bp latency", W'(n + 1), 32);
        for (int i = 0; i < 5; i++) begin
            WEN = (i == 2); labelIn = 4'd9;
            chk($sformatf("bp hold%0d req", i), W'(require), 1);
            chk($sformatf("bp hold%0d result", i), result, 32'd10);
            chk($sformatf("bp hold%0d label", i), W'(labelOut), 6);
            chk($sformatf("bp hold%0d avail", i), W'(available), 0);
            @(negedge clk);
        end
        WEN = 1'b0;
        check_out("bp");
        WEN = 1'b1; labelIn = 4'd9;
        grant("bp");
        quiet("bp after");

        // label 0 means no producer
        @(negedge clk);
        WEN = 1'b1; labelIn = '0; op = 2'b00; dataIn1 = 32'd8; dataIn2 = 32'd2;
        @(negedge clk);
        WEN = 1'b0;
        chk("label0 avail", W'(available), 1);
        quiet("label0");

        // asynchronous reset at iteration 10 discards the in-flight result
        issue(2'b00, 32'd77, 32'd7, 4'd3, 32'd11);
        repeat (10) @(negedge clk);
        #2 nRST = 1'b0;
        #1;
        chk("mid rst avail", W'(available), 1);
        chk("mid rst req", W'(require), 0);
        chk("mid rst result", result, 0);
        chk("mid rst label", W'(labelOut), 0);
        sb.delete();
        @(negedge clk);
        nRST = 1'b1;
        issue(2'b00, 32'd9, 32'd3, 4'd2, 32'd3);
        wait_req(n);
        chk("post rst latency", W'(n), 32);
        check_out("post rst");
        grant("post rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
